// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, state encoding and buffer entry type for the fetch controller
package fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 2-entry fetch FIFO; head lives in its own register so outputs are flop-driven
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign head    = slot0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // slot0 is always the head; a pop shifts slot1 forward
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            slot0 <= din;
          end else begin
            slot1 <= din;
          end
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencing, fault/halt/redirect FSM and decode handshake for instruction fetch
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BOOT_ADDR = 64'h0,
  parameter int                MEM_SIZE  = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               busy,
  output logic               fault,
  output logic [ADDR_W-1:0]  fault_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE) - ADDR_W'(4);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              legal;
  logic              pop;
  logic              push;
  logic              flush;
  logic              buf_full;
  logic              buf_empty;
  fetch_entry_t      buf_head;
  fetch_entry_t      new_entry;

  assign legal       = (pc[1:0] == 2'b00) && (pc <= LAST_ADDR);
  assign pop         = instr_valid && instr_ready;
  assign imem_addr   = pc;
  assign instr_valid = !buf_empty;
  assign instr       = buf_head.instr;
  assign instr_pc    = buf_head.pc;
  assign busy        = (state == RUN);
  assign fault       = (state == FAULT);
  assign new_entry   = '{pc: pc, instr: imem_data};

  // Priority in RUN: redirect, then halt, then fault check, then push
  always_comb begin
    push  = 1'b0;
    flush = 1'b0;
    if (state == RUN) begin
      if (redirect_valid) begin
        flush = 1'b1;
      end else if (!halt && legal && (!buf_full || pop)) begin
        push = 1'b1;
      end
    end else if (start) begin
      flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= BOOT_ADDR;
      fault_addr <= '0;
    end else if (state == RUN) begin
      if (redirect_valid) begin
        pc <= redirect_addr;
      end else if (halt) begin
        state <= HALTED;
      end else if (!legal) begin
        fault_addr <= pc;
        state      <= FAULT;
      end else if (push) begin
        pc <= pc + ADDR_W'(4);
      end
    end else if (start) begin
      pc    <= BOOT_ADDR;
      state <= RUN;
    end
  end

  fetch_buffer u_buffer (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (new_entry),
    .full  (buf_full),
    .empty (buf_empty),
    .head  (buf_head)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - scoreboard bench for fetch_controller against a 256-byte instruction ROM
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_addr = '0;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        busy;
  logic        fault;
  logic [63:0] fault_addr;

  logic [31:0] rom [0:63];
  logic [95:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 64'd256) ? rom[imem_addr[7:2]] : 32'h0;

  fetch_controller #(.BOOT_ADDR(64'h0), .MEM_SIZE(256)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .busy           (busy),
    .fault          (fault),
    .fault_addr     (fault_addr)
  );

  task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] pc);
    exp_q.push_back({pc, rom[pc[7:2]]});
  endtask

  // Every accepted handshake must match the next expected {pc, instr}
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      check_eq("q_nonempty", 96'(exp_q.size() != 0), 96'd1);
      if (exp_q.size() != 0) check_eq("deliver", {instr_pc, instr}, exp_q.pop_front());
    end
  end

  initial begin
    rom[0] = 32'h8b1f03e5;
    rom[1] = 32'hf84000a4;
    rom[2] = 32'h8b040086;
    rom[3] = 32'hf80010a6;
    for (int i = 4; i < 64; i++) rom[i] = 32'hd5030000 | 32'(i);

    #2;
    check_eq("rst_valid", 96'(instr_valid), 96'd0);
    check_eq("rst_instr", 96'(instr), 96'd0);
    check_eq("rst_pc", 96'(instr_pc), 96'd0);
    check_eq("rst_busy", 96'(busy), 96'd0);
    check_eq("rst_fault", 96'(fault), 96'd0);
    check_eq("rst_faddr", 96'(fault_addr), 96'd0);
    check_eq("rst_imem", 96'(imem_addr), 96'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Straight-line fetch; a second start mid-run must be ignored
    for (int a = 0; a < 16; a += 4) push_exp(64'(a));
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("sl_busy", 96'(busy), 96'd1);
    check_eq("sl_valid0", 96'(instr_valid), 96'd0);
    tick();
    check_eq("sl_valid1", 96'(instr_valid), 96'd1);
    check_eq("sl_first", 96'(instr), 96'h8b1f03e5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("sl_valid2", 96'(instr_valid), 96'd1);
    tick();
    check_eq("sl_valid3", 96'(instr_valid), 96'd1);
    tick();
    check_eq("sl_valid4", 96'(instr_valid), 96'd1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check_eq("sl_idle", 96'(instr_valid), 96'd0);
    check_eq("sl_halt_busy", 96'(busy), 96'd0);
    check_eq("sl_drained", 96'(exp_q.size()), 96'd0);

    // Backpressure: 5 stalled cycles, then drain 0, 4, 8
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_valid", 96'(instr_valid), 96'd1);
      check_eq("bp_imem", 96'(imem_addr), 96'd8);
      check_eq("bp_instr", 96'(instr), 96'h8b1f03e5);
      tick();
    end
    push_exp(64'd0);
    push_exp(64'd4);
    push_exp(64'd8);
    instr_ready = 1'b1;
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    check_eq("bp_empty", 96'(instr_valid), 96'd0);
    check_eq("bp_drained", 96'(exp_q.size()), 96'd0);

    // Halt at pc 8, drain, then restart from boot
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_eq("ht_pc8", 96'(imem_addr), 96'd8);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check_eq("ht_busy", 96'(busy), 96'd0);
    push_exp(64'd0);
    push_exp(64'd4);
    instr_ready = 1'b1;
    tick();
    tick();
    tick();
    check_eq("ht_drain", 96'(instr_valid), 96'd0);
    check_eq("ht_hold_pc", 96'(imem_addr), 96'd8);
    check_eq("ht_drained", 96'(exp_q.size()), 96'd0);
    push_exp(64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("ht_restart", {instr_pc, instr}, {64'd0, 32'h8b1f03e5});
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check_eq("ht_re_drained", 96'(exp_q.size()), 96'd0);

    // Redirect with PC 4 and 8 buffered; PC 4 is popped the same cycle
    push_exp(64'd0);
    push_exp(64'd4);
    push_exp(64'd12);
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    instr_ready = 1'b1;
    tick();
    check_eq("rd_head4", 96'(instr_pc), 96'd4);
    redirect_valid = 1'b1;
    redirect_addr = 64'd12;
    tick();
    redirect_valid = 1'b0;
    check_eq("rd_bubble", 96'(instr_valid), 96'd0);
    check_eq("rd_pc", 96'(imem_addr), 96'd12);
    tick();
    check_eq("rd_new", {instr_pc, instr}, {64'd12, 32'hf80010a6});
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check_eq("rd_drained", 96'(exp_q.size()), 96'd0);

    // Misaligned redirect target
    start = 1'b1;
    tick();
    start = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 64'd6;
    tick();
    redirect_valid = 1'b0;
    check_eq("mis_nofault", 96'(fault), 96'd0);
    tick();
    check_eq("mis_fault", 96'(fault), 96'd1);
    check_eq("mis_faddr", 96'(fault_addr), 96'd6);
    check_eq("mis_busy", 96'(busy), 96'd0);

    // Sequential run off the end of memory, restarted from FAULT
    for (int a = 0; a < 256; a += 4) push_exp(64'(a));
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("oor_clear", 96'(fault), 96'd0);
    check_eq("oor_busy", 96'(busy), 96'd1);
    for (int i = 0; i < 200 && !fault; i++) tick();
    check_eq("oor_fault", 96'(fault), 96'd1);
    check_eq("oor_faddr", 96'(fault_addr), 96'd256);
    check_eq("oor_drained", 96'(exp_q.size()), 96'd0);
    check_eq("oor_empty", 96'(instr_valid), 96'd0);

    // Asynchronous reset with a full buffer
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_eq("ar_full", 96'(instr_valid), 96'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_valid", 96'(instr_valid), 96'd0);
    check_eq("ar_imem", 96'(imem_addr), 96'd0);
    check_eq("ar_busy", 96'(busy), 96'd0);
    check_eq("ar_faddr", 96'(fault_addr), 96'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("ar_idle_busy", 96'(busy), 96'd0);
    check_eq("ar_idle_fault", 96'(fault), 96'd0);
    check_eq("ar_idle_valid", 96'(instr_valid), 96'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the combinational, byte-addressed instruction memory for the ARM CPU core. Holds the program counter, drives the memory read address, captures each 32-bit instruction into a 2-entry fetch buffer, and hands instructions to decode over a valid/ready handshake. Supports branch redirect, halt, and a fault stop on misaligned or out-of-range fetches. Sits between the instruction memory and the decode stage.

## Interface
- BOOT_ADDR, 64'h0: PC loaded on reset and on every `start`.
- MEM_SIZE, 256: instruction memory size in bytes. Must match the memory's `size`.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin fetching from BOOT_ADDR. Honoured in IDLE, HALTED and FAULT; ignored in RUN.
- halt  in  1  stop issuing fetches.
- redirect_valid  in  1  branch taken.
- redirect_addr  in  64  branch target.
- imem_addr  out  64  read address to instruction memory.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- instr_valid  out  1  buffer head is valid.
- instr_ready  in  1  decode accepts the head.
- instr  out  32  head instruction.
- instr_pc  out  64  head PC.
- busy  out  1  state == RUN.
- fault  out  1  state == FAULT.
- fault_addr  out  64  PC that faulted.

## Operation
- **States:** IDLE, RUN, HALTED, FAULT.
- **On reset:**
  - state = IDLE.
  - pc = BOOT_ADDR.
  - buffer empty.
  - instr_valid = 0, instr = 0, instr_pc = 0.
  - busy = 0, fault = 0, fault_addr = 0.
- **Start** (accepted in IDLE/HALTED/FAULT):
  - pc ← BOOT_ADDR.
  - Flush the buffer.
  - Clear fault.
  - Go to RUN.
- **Fetch** (RUN only): `imem_addr` = pc, always driven directly from the register. Each edge, the block pushes {pc, imem_data} and sets pc ← pc + 4 when all of the following hold:
  - the buffer is not full, or a pop happens in the same cycle;
  - there is no redirect;
  - there is no halt;
  - pc is legal.
- **Legal pc:** pc[1:0] == 0 and pc ≤ MEM_SIZE − 4, unsigned 64-bit compare.
- **Pop:** occurs when instr_valid && instr_ready.
- **Fault:** if pc is illegal at a fetch attempt in RUN:
  - No push.
  - fault_addr ← pc.
  - Go to FAULT.
  - The buffer keeps draining normally.
- **Redirect** (RUN, highest priority):
  - pc ← redirect_addr.
  - Buffer flushed.
  - No push that cycle.
  - A pop in the same cycle counts as delivered; every other entry is discarded.
  - An illegal target is detected at the next fetch attempt.
- **Halt** (RUN, below redirect):
  - Go to HALTED.
  - No push.
  - Buffer contents remain and drain normally.
  - pc is held.
- **Priority within RUN:** redirect > halt > fault check > push.
- **Outside RUN:** pc, imem_addr and the buffer are never pushed. Pops continue.
- **pc wrap:** pc + 4 is modulo 2^64. Wrap is unreachable while MEM_SIZE bounds hold.

## Timing
- **Start latency:** start sampled at edge N → busy high after N. First push at N+1 → instr_valid high after N+1, with instr = mem[BOOT_ADDR..+3].
- **Throughput:** 1 instruction/cycle sustained while instr_ready = 1.
- **Buffer full and instr_ready = 0:** pc is stalled. Push-and-pop in the same cycle is allowed when full; the count is unchanged.
- **Redirect latency:** redirect at edge N → buffer empty and pc = target after N. First new instruction valid after N+1, so the minimum bubble is 1 cycle.
- **Output stability:** instr, instr_pc and instr_valid are registered. instr and instr_pc must hold stable while instr_valid && !instr_ready.
- **Reset mid-operation:** asynchronous. Reset values apply immediately; pending buffer entries are lost.

## Structure
- **Package `fetch_pkg`:**
  - ADDR_W = 64, INSTR_W = 32.
  - State enum {IDLE, RUN, HALTED, FAULT}.
  - Packed struct fetch_entry_t {pc[63:0], instr[31:0]}.
- **Sub-module `fetch_buffer`:**
  - 2-entry FIFO of fetch_entry_t.
  - push/pop/flush inputs; full/empty/head outputs.
  - Flush has priority over push.
  - Same asynchronous active-high reset.
- **Top level:** FSM, pc register, legality check and handshake glue.

## Test plan
- **Straight-line fetch:** memory holds 8b1f03e5, f84000a4, 8b040086, f80010a6 at 0/4/8/12. Pulse start with instr_ready = 1. Required:
  - instr_valid first high 2 edges after start.
  - The four words appear on consecutive cycles, with instr_pc = 0, 4, 8, 12.
- **Backpressure:** instr_ready = 0 for 5 cycles after start. Required:
  - Buffer holds exactly 2 entries (PC 0, 4).
  - imem_addr stays 8.
  - instr stays 8b1f03e5.
  - On release, order is 0, 4, 8 with no loss or duplication.
- **Redirect:** redirect to 12 while the buffer holds PC 4 and 8, with instr_ready = 1 in the same cycle. Required:
  - PC 4 is delivered and PC 8 is discarded.
  - Next valid is f80010a6 at PC 12 after one bubble.
- **Faults:**
  - Redirect to 0x6: next cycle fault = 1, fault_addr = 6, busy = 0.
  - Sequential run reaching pc 256 with MEM_SIZE = 256: fault_addr = 256 after the word at 252 is delivered.
- **Halt/restart:** halt asserted when pc = 8. Required:
  - Entries already buffered drain.
  - No further fetches; busy = 0.
  - A later start refetches 8b1f03e5 from PC 0.
- **Async reset mid-run:** assert rst between edges with the buffer full. Required:
  - instr_valid = 0 and imem_addr = BOOT_ADDR immediately, before the next edge.
  - state IDLE after rst is released.
